// File: rtl/hyster_col_feeder.sv
// Raster-to-column streamer for the hysteresis stage: buffers two lines and emits
// one zero-padded 3-pixel vertical column (rows r-1, r, r+1) per cycle.
module hyster_col_feeder #(
  parameter int IMG_WIDTH  = 960,
  parameter int IMG_HEIGHT = 720,
  parameter int BIT_LENGTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIT_LENGTH-1:0] pixel_in,
  input  logic                  in_valid,
  output logic [BIT_LENGTH-1:0] pixel_out0,
  output logic [BIT_LENGTH-1:0] pixel_out1,
  output logic [BIT_LENGTH-1:0] pixel_out2,
  output logic                  enable,
  output logic                  done,
  output logic                  err
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q, col_d, col_step;
  logic [RW-1:0]         row_q, row_d, row_step;
  logic [BIT_LENGTH-1:0] o0_d, o1_d, o2_d;
  logic                  en_d, done_d, err_d, wr_en;
  logic                  last_col;
  logic [BIT_LENGTH-1:0] rd_a, rd_b;

  // line_a holds row r-1, line_b holds row r-2, both indexed by column
  logic [BIT_LENGTH-1:0] line_a [IMG_WIDTH];
  logic [BIT_LENGTH-1:0] line_b [IMG_WIDTH];

  always_comb begin
    rd_a     = line_a[col_q];
    rd_b     = line_b[col_q];
    last_col = (col_q == COL_LAST);
    col_step = last_col ? '0 : col_q + CW'(1);
    row_step = last_col ? row_q + RW'(1) : row_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_b[col_q] <= line_a[col_q];
      line_a[col_q] <= pixel_in;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    o0_d    = '0;
    o1_d    = '0;
    o2_d    = '0;
    en_d    = 1'b0;
    done_d  = done;
    err_d   = err;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          wr_en = 1'b1;
          col_d = col_step;
          row_d = row_step;
          // A one-pixel-wide image finishes row 0 on its first pixel
          if (IMG_WIDTH == 1)
            state_d = (IMG_HEIGHT == 1) ? S_FLUSH : S_STREAM;
          else
            state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (!in_valid) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          wr_en = 1'b1;
          col_d = col_step;
          row_d = row_step;
          if (last_col)
            state_d = (IMG_HEIGHT == 1) ? S_FLUSH : S_STREAM;
        end
      end
      S_STREAM: begin
        if (!in_valid) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          wr_en = 1'b1;
          en_d  = 1'b1;
          o0_d  = (row_q == ROW_ONE) ? '0 : rd_b;
          o1_d  = rd_a;
          o2_d  = pixel_in;
          col_d = col_step;
          row_d = row_step;
          if (last_col && row_q == ROW_LAST)
            state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        en_d  = 1'b1;
        o0_d  = (IMG_HEIGHT == 1) ? '0 : rd_b;
        o1_d  = rd_a;
        col_d = col_step;
        if (last_col)
          state_d = S_DONE;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      pixel_out0 <= '0;
      pixel_out1 <= '0;
      pixel_out2 <= '0;
      enable     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pixel_out0 <= o0_d;
      pixel_out1 <= o1_d;
      pixel_out2 <= o2_d;
      enable     <= en_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_hyster_col_feeder.sv
// Scoreboard bench for hyster_col_feeder: 4x3 frame instance plus a 4x1 instance.
module tb_hyster_col_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] pixel_in = '0;
  logic       in_valid = 1'b0;
  logic [4:0] pixel_out0, pixel_out1, pixel_out2;
  logic       enable, done, err;

  logic [4:0] h_pix = '0;
  logic       h_valid = 1'b0;
  logic [4:0] h_o0, h_o1, h_o2;
  logic       h_en, h_done, h_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_cnt = 0;
  int en_rises = 0;
  int first_en = -1;
  logic en_prev = 1'b0;
  logic [14:0] exp_q[$];

  hyster_col_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .BIT_LENGTH(5)) u_dut (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid),
    .pixel_out0(pixel_out0), .pixel_out1(pixel_out1), .pixel_out2(pixel_out2),
    .enable(enable), .done(done), .err(err));

  hyster_col_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(1), .BIT_LENGTH(5)) u_h1 (
    .clk(clk), .reset(reset), .pixel_in(h_pix), .in_valid(h_valid),
    .pixel_out0(h_o0), .pixel_out1(h_o1), .pixel_out2(h_o2),
    .enable(h_en), .done(h_done), .err(h_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [14:0] exp_col(input int h, input int rr, input int c);
    logic [4:0] a, b, d;
    a = (rr == 0) ? 5'd0 : 5'(4 * (rr - 1) + c + 1);
    b = 5'(4 * rr + c + 1);
    d = (rr == h - 1) ? 5'd0 : 5'(4 * (rr + 1) + c + 1);
    return {a, b, d};
  endfunction

  // Column monitor for the 4x3 instance: pops the scoreboard on every enable cycle
  always @(negedge clk) begin
    logic [14:0] got, e;
    got = {pixel_out0, pixel_out1, pixel_out2};
    checks++;
    if (enable) begin
      en_cnt++;
      if (!en_prev) begin
        en_rises++;
        if (first_en < 0) first_en = cyc;
      end
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL col_unexpected got=%h required=no column", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL col_value got=%h required=%h", got, e);
        end
      end
    end else if (got !== 15'd0) begin
      failures++;
      $display("FAIL idle_outputs got=%h required=0", got);
    end
    en_prev = enable;
  end

  task automatic drive(input logic v, input logic [4:0] p);
    @(negedge clk);
    in_valid = v;
    pixel_in = p;
  endtask

  task automatic clear_stats();
    @(posedge clk); #1;
    exp_q.delete();
    en_cnt = 0;
    en_rises = 0;
    first_en = -1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    h_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_stats();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({pixel_out0, pixel_out1, pixel_out2, enable, done, err} !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0",
               {pixel_out0, pixel_out1, pixel_out2, enable, done, err});
    end
    @(negedge clk);
    reset = 1'b0;
    clear_stats();
  endtask

  task automatic test_frame(input string name, input int idle, input int extra);
    int t10;
    t10 = 0;
    repeat (idle) drive(1'b0, 5'd0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        drive(1'b1, 5'(4 * r + c + 1));
        if (r == 1 && c == 0) t10 = cyc;
        if (r >= 1) exp_q.push_back(exp_col(3, r - 1, c));
        if (r == 2 && c == 3)
          for (int k = 0; k < 4; k++) exp_q.push_back(exp_col(3, 2, k));
      end
    end
    for (int k = 0; k < extra; k++) drive(1'b1, 5'd31);
    drive(1'b0, 5'd0);
    for (int i = 0; i < 30 && !done; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || enable !== 1'b0) begin
      failures++;
      $display("FAIL %s_end got=done%b err%b en%b required=done1 err0 en0", name, done, err, enable);
    end
    checks++;
    if (en_cnt != 12 || en_rises != 1) begin
      failures++;
      $display("FAIL %s_enable got=cycles%0d rises%0d required=cycles12 rises1", name, en_cnt, en_rises);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing got=%0d pending required=0", name, exp_q.size());
    end
    checks++;
    if (first_en != t10 + 1) begin
      failures++;
      $display("FAIL %s_latency got=%0d required=%0d", name, first_en, t10 + 1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || enable !== 1'b0) begin
      failures++;
      $display("FAIL %s_sticky got=done%b en%b required=done1 en0", name, done, enable);
    end
  endtask

  task automatic test_gap();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'(i + 1));
      if (i >= 4) exp_q.push_back(exp_col(3, 0, i - 4));
    end
    drive(1'b0, 5'd0);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || done !== 1'b1 || enable !== 1'b0) begin
      failures++;
      $display("FAIL gap_flags got=err%b done%b en%b required=err1 done1 en0", err, done, enable);
    end
    for (int i = 6; i < 12; i++) drive(1'b1, 5'(i + 1));
    drive(1'b0, 5'd0);
    repeat (6) @(negedge clk);
    checks++;
    if (en_cnt != 2 || exp_q.size() != 0 || err !== 1'b1) begin
      failures++;
      $display("FAIL gap_columns got=%0d pending%0d err%b required=2 pending0 err1",
               en_cnt, exp_q.size(), err);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 5'(i + 1));
      if (i >= 4) exp_q.push_back(exp_col(3, 0, i - 4));
    end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({pixel_out0, pixel_out1, pixel_out2, enable, done, err} !== 18'd0) begin
      failures++;
      $display("FAIL async_reset got=%h required=0",
               {pixel_out0, pixel_out1, pixel_out2, enable, done, err});
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_stats();
    test_frame("after_reset", 0, 0);
  endtask

  task automatic test_h1();
    int n;
    logic [14:0] got, e;
    n = 0;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      h_valid = 1'b1;
      h_pix = 5'(c + 1);
    end
    @(negedge clk);
    h_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (h_en) begin
        got = {h_o0, h_o1, h_o2};
        e = exp_col(1, 0, n);
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL h1_col%0d got=%h required=%h", n, got, e);
        end
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 4 || h_done !== 1'b1 || h_err !== 1'b0) begin
      failures++;
      $display("FAIL h1_end got=cols%0d done%b err%b required=cols4 done1 err0", n, h_done, h_err);
    end
  endtask

  initial begin
    test_reset();
    test_frame("gapless", 0, 0);
    apply_reset();
    test_frame("idle_start", 10, 0);
    test_gap();
    test_async_reset();
    test_h1();
    apply_reset();
    test_frame("extra_valid", 0, 6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
